// File: rtl/picorv_axil_bridge.sv
// PicoRV32 native memory bus to NUM_SLAVES AXI-Lite master ports, with error codes, timeout and hung-slot quarantine.
// Latency: zero-wait slave gives mem_ready 3 cycles after the request edge; decode miss or hung slot gives it in 1 cycle.
// Backpressure: slave wait states stretch the access; a slot that exceeds TIMEOUT is abandoned and quarantined until reset.
// Ports: clk/resetn; CPU side mem_*; flattened AXI-Lite masters m_* (slot k at [k*W +: W]);
//        err_valid/err_code/err_addr report the last failed access; hung is the sticky quarantine mask.
module picorv_axil_bridge #(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*16-1:0] SLAVE_ID   = {16'h6000, 16'h4000, 16'h2000, 16'h1000},
    parameter int                       TIMEOUT    = 255,
    parameter logic [31:0]              ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [NUM_SLAVES*32-1:0]  m_awaddr,
    output logic [NUM_SLAVES-1:0]     m_awvalid,
    input  logic [NUM_SLAVES-1:0]     m_awready,
    output logic [NUM_SLAVES*32-1:0]  m_wdata,
    output logic [NUM_SLAVES*4-1:0]   m_wstrb,
    output logic [NUM_SLAVES-1:0]     m_wvalid,
    input  logic [NUM_SLAVES-1:0]     m_wready,
    input  logic [NUM_SLAVES*2-1:0]   m_bresp,
    input  logic [NUM_SLAVES-1:0]     m_bvalid,
    output logic [NUM_SLAVES-1:0]     m_bready,
    output logic [NUM_SLAVES*32-1:0]  m_araddr,
    output logic [NUM_SLAVES-1:0]     m_arvalid,
    input  logic [NUM_SLAVES-1:0]     m_arready,
    input  logic [NUM_SLAVES*32-1:0]  m_rdata,
    input  logic [NUM_SLAVES*2-1:0]   m_rresp,
    input  logic [NUM_SLAVES-1:0]     m_rvalid,
    output logic [NUM_SLAVES-1:0]     m_rready,
    output logic                      err_valid,
    output logic [1:0]                err_code,
    output logic [31:0]               err_addr,
    output logic [NUM_SLAVES-1:0]     hung
);

    localparam int          SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP, S_DONE} state_t;

    state_t          state, state_d;
    logic [31:0]     addr_q, wdata_q, cnt;
    logic [3:0]      wstrb_q;
    logic [SW-1:0]   sel, dec_idx;
    logic [1:0]      code_q, code_d;
    logic            aw_done, w_done, dec_hit;
    logic            aw_v, w_v, b_r, ar_v, r_r;
    logic            aw_hs, w_hs, ar_hs, timeout_hit;
    logic            to_done, rd_load, set_hung;
    logic [31:0]     rd_val;
    logic [NUM_SLAVES-1:0] sel_oh;

    // AXI OKAY/EXOKAY -> 00, SLVERR -> 01, DECERR -> 10
    function automatic logic [1:0] map_resp(input logic [1:0] r);
        return r[1] ? {r[0], ~r[0]} : 2'b00;
    endfunction

    // Downward scan so the lowest matching slot wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (SLAVE_ID[k*16 +: 16] == mem_addr[31:16]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(k);
            end
        end
    end

    assign sel_oh = NUM_SLAVES'(1) << sel;

    assign aw_v  = (state == S_WRITE) && !aw_done;
    assign w_v   = (state == S_WRITE) && !w_done;
    assign b_r   = (state == S_WRESP);
    assign ar_v  = (state == S_READ);
    assign r_r   = (state == S_RRESP);

    assign aw_hs = aw_v && m_awready[sel];
    assign w_hs  = w_v  && m_wready[sel];
    assign ar_hs = ar_v && m_arready[sel];

    // Counter value TIMEOUT-1 during the Nth active cycle puts DONE exactly N cycles after IDLE.
    assign timeout_hit = (TIMEOUT != 0) && (cnt >= TO_LIM);

    always_comb begin
        state_d  = state;
        to_done  = 1'b0;
        code_d   = 2'b00;
        rd_load  = 1'b0;
        rd_val   = ERR_DATA;
        set_hung = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_valid) begin
                    if (!dec_hit) begin
                        state_d = S_DONE;
                        to_done = 1'b1;
                        code_d  = 2'b10;
                        rd_load = ~|mem_wstrb;
                    end else if (hung[dec_idx]) begin
                        state_d = S_DONE;
                        to_done = 1'b1;
                        code_d  = 2'b11;
                        rd_load = ~|mem_wstrb;
                    end else if (mem_wstrb != 4'b0000) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_d = S_WRESP;
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    code_d   = 2'b11;
                    set_hung = 1'b1;
                end
            end
            S_WRESP: begin
                // A response in the final cycle beats the timeout.
                if (m_bvalid[sel]) begin
                    state_d = S_DONE;
                    to_done = 1'b1;
                    code_d  = map_resp(m_bresp[int'(sel)*2 +: 2]);
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    code_d   = 2'b11;
                    set_hung = 1'b1;
                end
            end
            S_READ: begin
                if (ar_hs) begin
                    state_d = S_RRESP;
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    code_d   = 2'b11;
                    set_hung = 1'b1;
                    rd_load  = 1'b1;
                end
            end
            S_RRESP: begin
                if (m_rvalid[sel]) begin
                    state_d = S_DONE;
                    to_done = 1'b1;
                    code_d  = map_resp(m_rresp[int'(sel)*2 +: 2]);
                    rd_load = 1'b1;
                    rd_val  = m_rresp[int'(sel)*2 + 1] ? ERR_DATA : m_rdata[int'(sel)*32 +: 32];
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    code_d   = 2'b11;
                    set_hung = 1'b1;
                    rd_load  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            sel       <= '0;
            cnt       <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            code_q    <= 2'b00;
            err_code  <= 2'b00;
            err_addr  <= '0;
            mem_rdata <= '0;
            hung      <= '0;
        end else begin
            state <= state_d;
            if (state == S_IDLE) begin
                cnt     <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (mem_valid) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                    sel     <= dec_idx;
                end
            end else begin
                cnt <= cnt + 32'd1;
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            // Error report is registered on entry to DONE so it is stable during the err_valid pulse.
            if (to_done) begin
                code_q <= code_d;
                if (code_d != 2'b00) begin
                    err_code <= code_d;
                    err_addr <= (state == S_IDLE) ? mem_addr : addr_q;
                end
            end
            if (rd_load)  mem_rdata <= rd_val;
            if (set_hung) hung[sel] <= 1'b1;
        end
    end

    assign mem_ready = (state == S_DONE);
    assign err_valid = (state == S_DONE) && (code_q != 2'b00);

    assign m_awaddr  = {NUM_SLAVES{addr_q}};
    assign m_araddr  = {NUM_SLAVES{addr_q}};
    assign m_wdata   = {NUM_SLAVES{wdata_q}};
    assign m_wstrb   = {NUM_SLAVES{wstrb_q}};
    assign m_awvalid = aw_v ? sel_oh : '0;
    assign m_wvalid  = w_v  ? sel_oh : '0;
    assign m_bready  = b_r  ? sel_oh : '0;
    assign m_arvalid = ar_v ? sel_oh : '0;
    assign m_rready  = r_r  ? sel_oh : '0;

endmodule

// File: doc/picorv_axil_bridge.md
# picorv_axil_bridge

Parametrised bridge from the PicoRV32 native memory interface to NUM_SLAVES AXI-Lite master ports, replacing the direct memory-mapped decode in the SoC top. It decodes `mem_addr[31:16]` against a per-slave ID table, runs full AXI-Lite write and read handshakes, and completes the CPU access with a one-cycle `mem_ready`. It adds three things the direct decode does not have:

- Error responses.
- A per-transaction timeout.
- Sticky quarantine of hung slaves, with an error report port for firmware and the Zynq side.

## Interface

**Parameters**

- NUM_SLAVES, 4: number of AXI-Lite master ports (1–8).
- SLAVE_ID, {16'h6000,16'h4000,16'h2000,16'h1000}: packed NUM_SLAVES×16. Slot k is `SLAVE_ID[k*16+:16]`, matched against `mem_addr[31:16]`.
- TIMEOUT, 255: cycles allowed per AXI transaction. 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF: value returned on `mem_rdata` for a failed read.

**Ports**

All `m_*` buses are flattened, slot k at `[k*W +: W]`.

- clk  in  1  system clock. Connect to pl_clk0.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  CPU request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes. Nonzero means a write; zero means a read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  registered read data, valid while `mem_ready` is high.
- m_awaddr  out  32N  write address (the full `mem_addr`).
- m_awvalid  out  N.
- m_awready  in  N.
- m_wdata  out  32N.
- m_wstrb  out  4N.
- m_wvalid  out  N.
- m_wready  in  N.
- m_bresp  in  2N.
- m_bvalid  in  N.
- m_bready  out  N.
- m_araddr  out  32N.
- m_arvalid  out  N.
- m_arready  in  N.
- m_rdata  in  32N.
- m_rresp  in  2N.
- m_rvalid  in  N.
- m_rready  out  N.
- err_valid  out  1  one-cycle pulse when a transaction completes with a nonzero code.
- err_code  out  2  last error: 01 SLVERR, 10 DECERR, 11 TIMEOUT/hung. Held until the next error.
- err_addr  out  32  address of the last errored access. Held until the next error.
- hung  out  N  sticky mask of slots that have timed out.

## Operation

**States.** IDLE, WRITE, WRESP, READ, RRESP, DONE.

**IDLE**
- On `mem_valid`, register addr, wdata, wstrb and the selected slot.
- The selected slot is the lowest k whose `SLAVE_ID` matches.
- If no slot matches: go to DONE with code 10.
- If the matched slot has `hung[k]` set: go to DONE with code 11.
- Otherwise go to WRITE when `mem_wstrb != 0`, else to READ.

**WRITE**
- Assert `awvalid[k]` and `wvalid[k]` together.
- Each valid drops independently after its own handshake (`aw_done` / `w_done` flags).
- Go to WRESP when both handshakes are done. This covers AW and W handshaking in the same cycle or in either order.

**WRESP**
- Assert `bready[k]`.
- On `bvalid[k]`: go to DONE with code OKAY→00, SLVERR→01, DECERR→10. EXOKAY is treated as 00.

**READ**
- Assert `arvalid[k]`; on `arready` go to RRESP.

**RRESP**
- Assert `rready[k]`.
- On `rvalid[k]`: latch `rdata[k]`, or ERR_DATA if `rresp[1]` is set. Map the code as for writes and go to DONE.

**DONE**
- Hold `mem_ready` = 1 for exactly one cycle.
- Pulse `err_valid` if the code is nonzero, and update `err_code` / `err_addr`.
- Return to IDLE.
- On a failed read, `mem_rdata` = ERR_DATA. Failed writes are discarded.

**Timeout**
- The counter clears on leaving IDLE and increments in WRITE, WRESP, READ and RRESP.
- On reaching TIMEOUT:
  - drop all valids and readies for slot k;
  - set `hung[k]`;
  - go to DONE with code 11.
- This deliberately breaks the AXI valid-hold rule. The slot is quarantined until reset.

**General rules**
- Only slot k's channel signals are ever asserted. All other slots stay 0.
- Address, data and strobe outputs are driven to all slots from the registered values.

## Timing

**Reset.** Asynchronous assertion forces, immediately and at any point including mid-transaction:
- all valid and ready outputs to 0;
- `mem_ready`, `err_valid` = 0;
- `mem_rdata`, `err_addr` = 0, `err_code` = 00, `hung` = 0;
- state to IDLE.

Deassertion is synchronous in effect: the first request is sampled on the first rising edge after `resetn` goes high.

**Latency.** With the request sampled at edge 0 and a zero-wait slave:
- channel valids are high in cycle 1;
- the response handshakes in cycle 2;
- `mem_ready` is high in cycle 3.

Each wait cycle a slave adds on any channel adds one cycle. Decode-miss and hung-slot accesses give `mem_ready` in cycle 1.

**Back-to-back.** A new `mem_valid` in the cycle after DONE is accepted immediately (PicoRV32 updates the request on the same edge it sees `mem_ready`). There are no idle bubbles beyond DONE→IDLE.

**`mem_valid` outside IDLE.** It is ignored; the registered request is used.

**Timeout boundary.** TIMEOUT=N gives DONE exactly N cycles after leaving IDLE when the slave never responds. A response arriving in the same cycle the count reaches N wins, and no timeout is recorded.

## Test plan

- **Write, zero-wait slot 2.** `mem_addr`=0x4000_0000, wdata=0x3F80_0000, wstrb=F, slot 2 ready at once → `awvalid[2]`/`wvalid[2]` in cycle 1; `mem_ready` in cycle 3; `err_valid` stays 0.
- **Read with waits and SLVERR, slot 1.** `arready` delayed 3 cycles, `rvalid` with rresp=10 → `mem_ready` in cycle 6; `mem_rdata`=0xDEADBEEF; `err_code`=01; `err_addr`=0x2000_0000.
- **Split write handshakes.** `wready` 2 cycles before `awready` → `wvalid` drops after its handshake; `awvalid` is held; `bready` is asserted only after both complete; exactly one `mem_ready`.
- **Unmapped address.** Read of 0x8000_0004 → `mem_ready` in cycle 1; rdata=0xDEADBEEF; `err_code`=10; no `m_*` valid toggles.
- **Timeout and quarantine.** TIMEOUT=8, slot 3 never asserts `arready` → `arvalid[3]` drops, `mem_ready` at cycle 9, `hung`=4'b1000, `err_code`=11. The next access to 0x6000_0000 completes in cycle 1 with code 11.
- **Reset mid-write.** Assert `resetn`=0 while in WRESP → all outputs return to reset values asynchronously. After release, a read to slot 0 completes normally in 3 cycles with `hung`=0.
